// File: rtl/tow_pkg.sv
// Shared definitions for the tug-of-war round controller.
package tow_pkg;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned LFSR_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LIGHT,
        ST_RESULT,
        ST_HOLD,
        ST_GAMEOVER
    } state_t;

    // Score words that end the game (left or right side fully lit).
    localparam logic [7:0] WL_PATTERN = 8'b11100000;
    localparam logic [7:0] WR_PATTERN = 8'b00000111;

    // Fibonacci LFSR: taps at stages 16,14,13,11 map to bits 15,13,12,10.
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used to randomise the lights-off delay.
module lfsr16
    import tow_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] q
);

    // Shift left, feeding back the XOR of the tapped bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= LFSR_SEED;
        end else begin
            q <= {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/round_controller.sv
// Reaction-round sequencer: random wait, lights on, first push wins, display hold.
module round_controller
    import tow_pkg::*;
#(
    parameter logic [15:0] DELAY_MIN   = 16'd1000,
    parameter int unsigned RAND_BITS   = 8,
    parameter logic [15:0] HOLD_CYCLES = 16'd500,
    parameter logic [15:0] TIMEOUT     = 16'd4000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pbl,
    input  logic       pbr,
    input  logic [7:0] score,
    output logic       leds_on,
    output logic       winrnd,
    output logic       right,
    output logic       tie,
    output logic       game_over
);

    // Down-counter reload values; a zero-length phase still lasts one cycle.
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = (TIMEOUT == 16'd0) ? 16'd0 : TIMEOUT - 16'd1;
    localparam logic [CNT_W-1:0] HOLD_LOAD    = (HOLD_CYCLES == 16'd0) ? 16'd0 : HOLD_CYCLES - 16'd1;
    localparam logic [LFSR_W-1:0] RAND_MASK   = 16'((32'd1 << RAND_BITS) - 32'd1);

    state_t              state;
    logic [CNT_W-1:0]    counter;
    logic [LFSR_W-1:0]   lfsr_q;
    logic [1:0]          sync_l;
    logic [1:0]          sync_r;
    logic                prev_l;
    logic                prev_r;
    logic                level_l;
    logic                level_r;
    logic                push_l;
    logic                push_r;
    logic [CNT_W:0]      delay_sum;
    logic [CNT_W-1:0]    wait_load;

    lfsr16 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    // Two-flop synchronizers plus a delayed copy for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_l <= 2'b00;
            sync_r <= 2'b00;
            prev_l <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            sync_l <= {sync_l[0], pbl};
            sync_r <= {sync_r[0], pbr};
            prev_l <= sync_l[1];
            prev_r <= sync_r[1];
        end
    end

    assign level_l = sync_l[1];
    assign level_r = sync_r[1];
    assign push_l  = sync_l[1] & ~prev_l;
    assign push_r  = sync_r[1] & ~prev_r;

    // Randomised wait length, saturating instead of wrapping.
    assign delay_sum = {1'b0, DELAY_MIN} + {1'b0, lfsr_q & RAND_MASK};
    assign wait_load = delay_sum[CNT_W] ? 16'hFFFF : delay_sum[CNT_W-1:0];

    // Round FSM with registered outputs and the shared phase counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            counter   <= '0;
            leds_on   <= 1'b0;
            winrnd    <= 1'b0;
            right     <= 1'b0;
            tie       <= 1'b0;
            game_over <= 1'b0;
        end else begin
            winrnd <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!level_l && !level_r) begin
                        if (score == WL_PATTERN || score == WR_PATTERN) begin
                            state     <= ST_GAMEOVER;
                            game_over <= 1'b1;
                        end else begin
                            state   <= ST_WAIT;
                            counter <= wait_load;
                        end
                    end
                end
                ST_WAIT: begin
                    if (push_l || push_r) begin
                        state  <= ST_RESULT;
                        winrnd <= 1'b1;
                        right  <= push_r & ~push_l;
                        tie    <= push_l & push_r;
                    end else if (counter == '0) begin
                        state   <= ST_LIGHT;
                        leds_on <= 1'b1;
                        counter <= TIMEOUT_LOAD;
                    end else begin
                        counter <= counter - 16'd1;
                    end
                end
                ST_LIGHT: begin
                    if (push_l || push_r) begin
                        state  <= ST_RESULT;
                        winrnd <= 1'b1;
                        right  <= push_r & ~push_l;
                        tie    <= push_l & push_r;
                    end else if (counter == '0) begin
                        state   <= ST_HOLD;
                        leds_on <= 1'b0;
                        counter <= HOLD_LOAD;
                    end else begin
                        counter <= counter - 16'd1;
                    end
                end
                ST_RESULT: begin
                    state   <= ST_HOLD;
                    leds_on <= 1'b0;
                    counter <= HOLD_LOAD;
                end
                ST_HOLD: begin
                    if (counter == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        counter <= counter - 16'd1;
                    end
                end
                ST_GAMEOVER: begin
                    leds_on <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller with short timing parameters.
module tb_round_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       pbl;
    logic       pbr;
    logic [7:0] score;
    logic       leds_on;
    logic       winrnd;
    logic       right;
    logic       tie;
    logic       game_over;

    int checks      = 0;
    int failures    = 0;
    int win_count   = 0;
    int leds_hi_cnt = 0;

    round_controller #(
        .DELAY_MIN   (16'd4),
        .RAND_BITS   (2),
        .HOLD_CYCLES (16'd3),
        .TIMEOUT     (16'd10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pbl       (pbl),
        .pbr       (pbr),
        .score     (score),
        .leds_on   (leds_on),
        .winrnd    (winrnd),
        .right     (right),
        .tie       (tie),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock, then sample just after the edge and keep running tallies.
    task automatic tick();
        @(posedge clk);
        #1;
        if (winrnd === 1'b1) win_count++;
        if (leds_on === 1'b1) leds_hi_cnt++;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_leds(input logic lvl, input int budget);
        int n = 0;
        while (leds_on !== lvl && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check1({tag, "_leds"}, leds_on, 1'b0);
        check1({tag, "_win"},  winrnd, 1'b0);
        check1({tag, "_right"}, right, 1'b0);
        check1({tag, "_tie"},  tie, 1'b0);
        check1({tag, "_go"},   game_over, 1'b0);
    endtask

    initial begin
        int n;
        int wc;
        int lh;

        rst   = 1'b1;
        pbl   = 1'b0;
        pbr   = 1'b0;
        score = 8'h00;
        #2;
        check_all_zero("rst_async");
        ticks(2);
        check_all_zero("rst_held");

        // First WAIT after reset loads 4 + (ACE1 & 3) = 5: LIGHT after 7 edges.
        rst = 1'b0;
        ticks(6);
        check1("first_wait_off", leds_on, 1'b0);
        tick();
        check1("first_wait_on", leds_on, 1'b1);

        // No push: lights stay on for exactly TIMEOUT cycles, no winrnd.
        n = 0;
        while (leds_on === 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checkn("timeout_len", n, 10);
        checkn("timeout_no_win", win_count, 0);

        // Right push in LIGHT.
        wait_leds(1'b1, 100);
        check1("light_reached_r", leds_on, 1'b1);
        pbr = 1'b1;
        ticks(2);
        pbr = 1'b0;
        tick();
        check1("r_win", winrnd, 1'b1);
        check1("r_right", right, 1'b1);
        check1("r_tie", tie, 1'b0);
        check1("r_leds", leds_on, 1'b1);
        tick();
        check1("r_win_drop", winrnd, 1'b0);
        check1("r_leds_drop", leds_on, 1'b0);
        check1("r_right_hold", right, 1'b1);
        lh = leds_hi_cnt;

        // Left jumps the light: HOLD 3, IDLE, then WAIT of at least 5 cycles.
        ticks(4);
        pbl = 1'b1;
        ticks(2);
        pbl = 1'b0;
        tick();
        check1("jump_win", winrnd, 1'b1);
        check1("jump_right", right, 1'b0);
        check1("jump_tie", tie, 1'b0);
        check1("jump_leds", leds_on, 1'b0);
        checkn("jump_no_light", leds_hi_cnt - lh, 0);
        tick();
        check1("jump_win_drop", winrnd, 1'b0);

        // Simultaneous pushes in LIGHT.
        wait_leds(1'b1, 100);
        check1("light_reached_t", leds_on, 1'b1);
        pbl = 1'b1;
        pbr = 1'b1;
        ticks(2);
        pbl = 1'b0;
        pbr = 1'b0;
        tick();
        check1("tie_win", winrnd, 1'b1);
        check1("tie_tie", tie, 1'b1);
        check1("tie_right", right, 1'b0);
        check1("tie_leds", leds_on, 1'b1);
        ticks(2);
        check1("tie_hold", tie, 1'b1);
        check1("tie_win_drop", winrnd, 1'b0);

        // Left held across the round end: IDLE must wait for release.
        wait_leds(1'b1, 100);
        check1("light_reached_h", leds_on, 1'b1);
        wc = win_count;
        pbl = 1'b1;
        ticks(4);
        lh = leds_hi_cnt;
        ticks(36);
        checkn("held_single_win", win_count - wc, 1);
        checkn("held_no_light", leds_hi_cnt - lh, 0);
        pbl = 1'b0;
        wait_leds(1'b1, 40);
        check1("released_light", leds_on, 1'b1);

        // Winning score: round finishes, then the block halts.
        score = 8'b00000111;
        pbr = 1'b1;
        ticks(2);
        pbr = 1'b0;
        tick();
        check1("go_last_win", winrnd, 1'b1);
        n = 0;
        while (game_over !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check1("go_set", game_over, 1'b1);
        wc = win_count;
        repeat (3) begin
            pbl = 1'b1;
            ticks(3);
            pbl = 1'b0;
            pbr = 1'b1;
            ticks(3);
            pbr = 1'b0;
            ticks(2);
        end
        checkn("go_no_win", win_count - wc, 0);
        check1("go_hold", game_over, 1'b1);
        check1("go_leds", leds_on, 1'b0);

        // Reset leaves GAMEOVER and restarts the LFSR.
        rst = 1'b1;
        #2;
        check1("go_rst_clear", game_over, 1'b0);
        score = 8'h00;
        tick();
        rst = 1'b0;
        ticks(6);
        check1("re_wait_off", leds_on, 1'b0);
        tick();
        check1("re_wait_on", leds_on, 1'b1);

        // Reset during RESULT clears everything immediately.
        pbr = 1'b1;
        ticks(2);
        pbr = 1'b0;
        tick();
        check1("pre_rst_win", winrnd, 1'b1);
        check1("pre_rst_right", right, 1'b1);
        rst = 1'b1;
        #1;
        check_all_zero("rst_in_result");
        tick();
        check1("rst_in_result_win", winrnd, 1'b0);
        rst = 1'b0;
        ticks(6);
        check1("post_rst_wait_off", leds_on, 1'b0);
        tick();
        check1("post_rst_wait_on", leds_on, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/round_controller.md
ROUND_CONTROLLER -- requirements
Module: round_controller

Interface
REQ-001 Parameter DELAY_MIN, default 16'd1000, minimum lights-off wait in cycles.
REQ-002 Parameter RAND_BITS, default 8, LFSR bits added to DELAY_MIN (1..15).
REQ-003 Parameter HOLD_CYCLES, default 16'd500, post-round display hold in cycles.
REQ-004 Parameter TIMEOUT, default 16'd4000, lights-on cycles before a round is abandoned.
REQ-005 clk  input  1  system clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 pbl  input  1  left player button, asynchronous, active-high.
REQ-008 pbr  input  1  right player button, asynchronous, active-high.
REQ-009 score  input  8  scorer output word, [7] leftmost, [0] rightmost.
REQ-010 leds_on  output  1  lights-on indication; also tells the scorer whether a push was proper.
REQ-011 winrnd  output  1  one-cycle pulse that a round was decided.
REQ-012 right  output  1  qualifies winrnd: 1 = right pushed first, 0 = left pushed first.
REQ-013 tie  output  1  qualifies winrnd: both pushed in the same cycle.
REQ-014 game_over  output  1  a win pattern was detected; the block is halted.

Function
REQ-015 Each button SHALL pass through a 2-flop synchronizer; only rising edges of the synchronized level count as pushes.
REQ-016 Sequence: IDLE -> WAIT -> LIGHT -> RESULT -> HOLD -> IDLE; GAMEOVER is terminal.
REQ-017 IDLE: the block SHALL stay until both synchronized buttons are low.
REQ-017a IDLE: if score equals 8'b11100000 or 8'b00000111, the next state SHALL be GAMEOVER; otherwise WAIT.
REQ-018 On WAIT entry, the counter SHALL load DELAY_MIN + lfsr[RAND_BITS-1:0] and decrement once per cycle; leds_on=0.
REQ-019 WAIT: the counter at 0 with no push SHALL move to LIGHT, and leds_on SHALL be 1 from the first LIGHT cycle.
REQ-020 A push edge in WAIT (jump the light) SHALL go to RESULT with leds_on=0; this includes the cycle the counter reaches 0.
REQ-021 A push edge in LIGHT SHALL go to RESULT with leds_on=1.
REQ-022 LIGHT: after TIMEOUT cycles with no push, the block SHALL go to HOLD without asserting winrnd.
REQ-023 RESULT SHALL last exactly 1 cycle.
REQ-023a In RESULT, winrnd=1; right and tie are registered from the deciding edges; leds_on keeps its deciding-cycle value.
REQ-024 Deciding edges from both players in the same cycle SHALL give tie=1, right=0.
REQ-024a Otherwise right=1 for pbr and right=0 for pbl, with tie=0.
REQ-025 right and tie SHALL hold their values until the next RESULT; winrnd SHALL be 0 outside RESULT.
REQ-026 HOLD: leds_on=0 for HOLD_CYCLES cycles (minimum 1), then IDLE; pushes SHALL be ignored.
REQ-027 GAMEOVER: game_over=1, leds_on=0, winrnd=0, held until rst.
REQ-028 The LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1, advancing every cycle in every state.
REQ-029 Counter width SHALL be 16 bits; the DELAY_MIN + random sum SHALL saturate at 16'hFFFF.

Reset
REQ-030 rst SHALL immediately force IDLE, leds_on=0, winrnd=0, right=0, tie=0, game_over=0, counter=0, LFSR=16'hACE1, and synchronizers=0.
REQ-031 A reset during any state, including RESULT, SHALL suppress that cycle's winrnd.

Structure
REQ-032 Shared package tow_pkg SHALL hold: the state enum; WL_PATTERN 8'b11100000 and WR_PATTERN 8'b00000111; LFSR_SEED 16'hACE1 and the tap mask.
REQ-033 The LFSR SHALL be the sub-module lfsr16 (clk, rst, q[15:0]); synchronizers and edge detection SHALL stay inline.

Verification (DELAY_MIN=4, RAND_BITS=2, HOLD_CYCLES=3, TIMEOUT=10)
REQ-034 pbr pulse in LIGHT -> one winrnd cycle with right=1, tie=0, leds_on=1; then 3 HOLD cycles, then IDLE.
REQ-035 pbl pulse in WAIT -> winrnd with right=0, leds_on=0; LIGHT never entered that round.
REQ-036 pbl and pbr rising in the same cycle in LIGHT -> winrnd=1, tie=1, right=0.
REQ-037 No push in LIGHT -> after 10 cycles, HOLD with winrnd never asserted.
REQ-037a pbl held high across the round end -> the block stays in IDLE until it is released.
REQ-038 score=8'b00000111 at IDLE -> game_over=1 and no further winrnd under pushes.
REQ-038a rst asserted in RESULT -> all outputs 0 at once; after release, the first WAIT loads 4+(16'hACE1 LFSR bits [1:0]).
